cordic16_rotate_iter: RTL and testbench
=======================================

// Module: cordic16_rotate_iter
// PURPOSE
//  Iterative 16-bit CORDIC rotation engine: one micro-rotation per clock on registered x/y/z.
//  Per-iteration shift is an arithmetic (sign-extending) right shift of x/y by i.
//  It is built as a cascade of the fixed logshift1/2/4/8 stages, selected by iteration-counter bits.
//  Sits between the operand-capture logic and the result/scaling path of the cordic16 datapath.
// PARAMETERS
//  ITER  15  number of micro-rotations, legal 1..15 (shift amounts 0..ITER-1)
// PORTS
//  clk      in   1   rising-edge clock; single clock domain
//  reset    in   1   synchronous, active-high reset
//  start    in   1   request; sampled only in IDLE
//  x_in     in   16  signed Q1.14 X operand
//  y_in     in   16  signed Q1.14 Y operand
//  z_in     in   16  signed Q3.13 angle, radians, |z_in| <= 12868 (pi/2)
//  busy     out  1   high from cycle after accepted start until done cycle (exclusive)
//  done     out  1   one-cycle pulse, results valid
//  x_out    out  16  signed Q1.14 result X, held until next accepted start
//  y_out    out  16  signed Q1.14 result Y, held
//  z_out    out  16  signed Q3.13 residual angle, held
// BEHAVIOUR
//  - Reset: state=IDLE, iteration count=0, x/y/z regs=0, busy=0, done=0, x_out=y_out=z_out=0.
//  - FSM IDLE -> RUN on start; RUN -> DONE after ITER iterations (or -> SCALE, see CONFIGURATION); DONE -> IDLE.
//  - IDLE + start at cycle 0: latch x_in/y_in/z_in, i=0. RUN in cycles 1..ITER. done=1 in cycle ITER+1.
//    Outputs update in that same cycle, so latency is ITER+1 cycles start->done.
//  - start while busy or in DONE cycle: ignored, no queueing. start in IDLE in the cycle after done is accepted.
//  - Micro-rotation i: d=+1 if z>=0 else -1.
//    x'=x-d*(y>>>i); y'=y+d*(x>>>i); z'=z-d*ATAN[i].
//    All 16-bit two's-complement; wrap on overflow, no saturation.
//  - ATAN[i] = round(atan(2^-i)*8192), constant table, i=0..14:
//    6434,3798,2007,1019,511,256,128,64,32,16,8,4,2,1,0
//  - Shifter: 4 cascaded fixed-shift stages by 1/2/4/8, enabled by count bits [0..3]; vacated MSBs filled with sign.
//  - Caller keeps sqrt(x_in^2+y_in^2) <= 19000 so gain 1.6468 stays in range; outside this, results wrap (no flag).
//  - reset mid-operation: abort immediately to reset values; no done pulse for the aborted op.
//  - Outputs change only in the done cycle.
// CONFIGURATION
//  CORDIC_GAIN_COMP_EN defined:
//   - Extra state SCALE after last RUN cycle: x,y multiplied by K=9949 (0.60725 Q1.14).
//   - Uses a 32-bit signed product, then arithmetic >>>14, truncated to 16 bits. z untouched.
//   - done in cycle ITER+2; busy covers SCALE.
//  Not defined: no SCALE state; raw gain-scaled x/y, done in cycle ITER+1. Macro does not change ports.
// TESTING
//  1. reset held 3 cycles mid-RUN -> busy=0, done=0, outputs 0; next start runs full op normally.
//  2. x_in=9949, y_in=0, z_in=6434 (pi/4), macro off, ITER=15
//     -> done exactly 16 cycles after start; x_out,y_out = 11585 +/-6; |z_out| <= 4.
//  3. x_in=16384, y_in=0, z_in=0, macro off -> x_out = 26981 +/-6, |y_out| <= 6.
//     Macro on -> x_out = 16384 +/-8, done after 17 cycles.
//  4. z_in=-12868 (-pi/2), x_in=9949, y_in=0, macro off -> x_out ~0 (+/-8), y_out = -16384 +/-8.
//  5. start held high continuously for 60 cycles -> back-to-back ops.
//     Each done pulse is one cycle, spaced ITER+2 cycles apart (one IDLE cycle between ops).
//     Outputs stable between pulses; mid-op input changes ignored.
//  6. ITER=1 build, x_in=1000, y_in=2000, z_in=100 -> done in cycle 2; x_out=-1000, y_out=3000, z_out=-6334.

Source files
------------

// File: rtl/cordic16_rotate_iter.sv
// Iterative 16-bit CORDIC rotation: one micro-rotation per clock on registered x/y/z.
// Optional gain compensation (extra SCALE state) is enabled by defining CORDIC_GAIN_COMP_EN.
module cordic16_rotate_iter #(
  parameter int ITER = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] z_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] x_out,
  output logic [15:0] y_out,
  output logic [15:0] z_out
);

  typedef enum logic [1:0] {IDLE, RUN, SCALE, DONE} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt;
  logic signed [15:0] x_r, y_r, z_r;
  logic signed [15:0] xs, ys, x_nx, y_nx, z_nx;
  logic               last;

  // Arithmetic right shift built from fixed 1/2/4/8 stages keyed by count bits.
  function automatic logic signed [15:0] shr(input logic signed [15:0] v, input logic [3:0] s);
    logic signed [15:0] a;
    a = s[0] ? (v >>> 1) : v;
    a = s[1] ? (a >>> 2) : a;
    a = s[2] ? (a >>> 4) : a;
    a = s[3] ? (a >>> 8) : a;
    return a;
  endfunction

  function automatic logic signed [15:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    atan_lut = 16'sd6434;
      4'd1:    atan_lut = 16'sd3798;
      4'd2:    atan_lut = 16'sd2007;
      4'd3:    atan_lut = 16'sd1019;
      4'd4:    atan_lut = 16'sd511;
      4'd5:    atan_lut = 16'sd256;
      4'd6:    atan_lut = 16'sd128;
      4'd7:    atan_lut = 16'sd64;
      4'd8:    atan_lut = 16'sd32;
      4'd9:    atan_lut = 16'sd16;
      4'd10:   atan_lut = 16'sd8;
      4'd11:   atan_lut = 16'sd4;
      4'd12:   atan_lut = 16'sd2;
      4'd13:   atan_lut = 16'sd1;
      default: atan_lut = 16'sd0;
    endcase
  endfunction

  assign last = (cnt == 4'(ITER - 1));
  assign xs   = shr(x_r, cnt);
  assign ys   = shr(y_r, cnt);

  // Direction from the sign of the residual angle: z >= 0 rotates positive.
  always_comb begin
    if (!z_r[15]) begin
      x_nx = x_r - ys;
      y_nx = y_r + xs;
      z_nx = z_r - atan_lut(cnt);
    end else begin
      x_nx = x_r + ys;
      y_nx = y_r - xs;
      z_nx = z_r + atan_lut(cnt);
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [31:0] px, py;
  logic signed [15:0] x_sc, y_sc;
  assign px   = 32'(x_r) * 32'sd9949;
  assign py   = 32'(y_r) * 32'sd9949;
  assign x_sc = 16'(px >>> 14);
  assign y_sc = 16'(py >>> 14);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
`ifdef CORDIC_GAIN_COMP_EN
        if (last) state_nxt = SCALE;
`else
        if (last) state_nxt = DONE;
`endif
      end
      SCALE: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers load on the edge that enters DONE, so they are valid with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      x_r   <= '0;
      y_r   <= '0;
      z_r   <= '0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x_r <= x_in;
          y_r <= y_in;
          z_r <= z_in;
          cnt <= '0;
        end
        RUN: begin
          x_r <= x_nx;
          y_r <= y_nx;
          z_r <= z_nx;
          cnt <= cnt + 4'd1;
`ifndef CORDIC_GAIN_COMP_EN
          if (last) begin
            x_out <= x_nx;
            y_out <= y_nx;
            z_out <= z_nx;
          end
`endif
        end
`ifdef CORDIC_GAIN_COMP_EN
        SCALE: begin
          x_out <= x_sc;
          y_out <= y_sc;
          z_out <= z_r;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic16_rotate_iter.sv
// Scoreboard bench for cordic16_rotate_iter: ITER=15 instance plus an ITER=1 instance.
module tb_cordic16_rotate_iter;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT  = 17;
  localparam int LAT1 = 3;
`else
  localparam int LAT  = 16;
  localparam int LAT1 = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x_in = '0, y_in = '0, z_in = '0;
  logic        busy, done;
  logic [15:0] x_out, y_out, z_out;

  logic        start1 = 1'b0;
  logic [15:0] x_in1 = '0, y_in1 = '0, z_in1 = '0;
  logic        busy1, done1;
  logic [15:0] x_out1, y_out1, z_out1;

  cordic16_rotate_iter #(.ITER(15)) dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out), .z_out(z_out));

  cordic16_rotate_iter #(.ITER(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .x_in(x_in1), .y_in(y_in1), .z_in(z_in1),
    .busy(busy1), .done(done1), .x_out(x_out1), .y_out(y_out1), .z_out(z_out1));

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] x, y, z;
    int due;
    int kind;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int   cyc = 0;
  int   acc = -1000;
  int   free_cyc = 0;
  bit   mon_en = 0;
  int   n_chk = 0, n_pass = 0;
  int   atan_t[15] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic int near(input int a, input int b, input int tol);
    return ((a - b) <= tol && (b - a) <= tol) ? 1 : 0;
  endfunction

  function automatic exp_t model(input int xi, input int yi, input int zi, input int n);
    exp_t m;
    logic signed [15:0] x, y, z, xs, ys;
    x = 16'(xi); y = 16'(yi); z = 16'(zi);
    for (int i = 0; i < n; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (z >= 0) begin
        x = x - ys; y = y + xs; z = z - 16'(atan_t[i]);
      end else begin
        x = x + ys; y = y - xs; z = z + 16'(atan_t[i]);
      end
    end
`ifdef CORDIC_GAIN_COMP_EN
    x = 16'((int'(x) * 9949) >>> 14);
    y = 16'((int'(y) * 9949) >>> 14);
`endif
    m.x = x; m.y = y; m.z = z; m.due = 0; m.kind = 0;
    return m;
  endfunction

  // One cycle of stimulus; the bench decides acceptance from its own timing model.
  task automatic drive(input bit st, input int xv, input int yv, input int zv, input int kind);
    exp_t e;
    start = st; x_in = 16'(xv); y_in = 16'(yv); z_in = 16'(zv);
    if (st && !reset && cyc >= free_cyc) begin
      e = model(xv, yv, zv, 15);
      e.due = cyc + LAT;
      e.kind = kind;
      q.push_back(e);
      acc = cyc;
      free_cyc = cyc + LAT + 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; start = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      q.delete();
      held.x = '0; held.y = '0; held.z = '0;
      acc = -1000;
      mon_en = 1;
    end
    reset = 1'b0;
    free_cyc = cyc;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit   exp_done;
      exp_t e;
      exp_done = (q.size() > 0) && (q[0].due == cyc);
      chk("done", int'(done), int'(exp_done));
      chk("busy", int'(busy), int'((cyc > acc) && (cyc < acc + LAT)));
      if (done && exp_done) begin
        e = q.pop_front();
        chk("x_out", int'($signed(x_out)), int'(e.x));
        chk("y_out", int'($signed(y_out)), int'(e.y));
        chk("z_out", int'($signed(z_out)), int'(e.z));
        held = e;
`ifndef CORDIC_GAIN_COMP_EN
        if (e.kind == 2) begin
          chk("t2_x_tol", near(int'($signed(x_out)), 11585, 6), 1);
          chk("t2_y_tol", near(int'($signed(y_out)), 11585, 6), 1);
          chk("t2_z_tol", near(int'($signed(z_out)), 0, 4), 1);
        end
        if (e.kind == 3) begin
          chk("t3_x_tol", near(int'($signed(x_out)), 26981, 6), 1);
          chk("t3_y_tol", near(int'($signed(y_out)), 0, 6), 1);
        end
        if (e.kind == 4) begin
          chk("t4_x_tol", near(int'($signed(x_out)), 0, 8), 1);
          chk("t4_y_tol", near(int'($signed(y_out)), -16384, 8), 1);
        end
`else
        if (e.kind == 3) chk("t3g_x_tol", near(int'($signed(x_out)), 16384, 8), 1);
`endif
      end else begin
        chk("x_hold", int'($signed(x_out)), int'(held.x));
        chk("y_hold", int'($signed(y_out)), int'(held.y));
        chk("z_hold", int'($signed(z_out)), int'(held.z));
      end
    end
  end

  initial begin
    exp_t m1;
    int   c0;
    held.x = '0; held.y = '0; held.z = '0; held.due = 0; held.kind = 0;
    #1;
    do_reset(3);
    repeat (2) drive(0, 0, 0, 0, 0);

    drive(1, 9949, 0, 6434, 2);
    repeat (LAT + 2) drive(0, 0, 0, 0, 0);
    drive(1, 16384, 0, 0, 3);
    repeat (LAT + 2) drive(0, 0, 0, 0, 0);
    drive(1, 9949, 0, -12868, 4);
    repeat (LAT + 2) drive(0, 0, 0, 0, 0);

    // Abort mid-RUN; outputs were nonzero, so the hold check sees the clear.
    drive(1, 5000, -3000, 2000, 0);
    repeat (5) drive(0, 0, 0, 0, 0);
    do_reset(3);
    drive(1, -7000, 4000, -9000, 0);
    repeat (LAT + 2) drive(0, 0, 0, 0, 0);

    // start held high: back-to-back ops, inputs changing every cycle.
    for (int k = 0; k < 60; k++)
      drive(1, int'($urandom_range(0, 18000)) - 9000, int'($urandom_range(0, 18000)) - 9000,
            int'($urandom_range(0, 25736)) - 12868, 0);
    repeat (LAT + 3) drive(0, 0, 0, 0, 0);
    chk("sb_empty", q.size(), 0);
    mon_en = 0;

    // ITER=1 instance.
    x_in1 = 16'(1000); y_in1 = 16'(2000); z_in1 = 16'(100); start1 = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) chk("it1_busy", int'(busy1), 1);
      if (done1) break;
    end
    chk("it1_lat", cyc - c0, LAT1);
    m1 = model(1000, 2000, 100, 1);
    chk("it1_x", int'($signed(x_out1)), int'(m1.x));
    chk("it1_y", int'($signed(y_out1)), int'(m1.y));
    chk("it1_z", int'($signed(z_out1)), int'(m1.z));
`ifndef CORDIC_GAIN_COMP_EN
    chk("it1_x_const", int'($signed(x_out1)), -1000);
    chk("it1_y_const", int'($signed(y_out1)), 3000);
`endif
    chk("it1_z_const", int'($signed(z_out1)), -6334);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
